// File: rtl/id_pkg.sv
// id_pkg: MIPS-32 opcode/funct constants, ALU op encoding and the decoded-instruction record
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_LUI  = 4'd6,
        ALU_PASS = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  dst;
        logic        wr_en;
        alu_op_e     alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_decoder.sv
// id_decoder: combinational MIPS-32 field extraction and control decode
module id_decoder
    import id_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic        use_rt,
    output dec_t        dec
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
    // I-type reads rt only as store data or branch comparand
    assign use_rt = op == OP_RTYPE || op == OP_SW || op == OP_BEQ;

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_PASS;
        dec.dst    = rt;
        case (op)
            OP_RTYPE: begin
                dec.dst = rd;
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLL: begin
                        dec.alu_op = ALU_SLL;
                        dec.imm    = {27'd0, shamt};
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec.alu_op = ALU_ADD;
                dec.imm    = sext16(imm16);
            end
            OP_LW: begin
                dec.alu_op = ALU_ADD;
                dec.imm    = sext16(imm16);
                dec.mem_rd = 1'b1;
            end
            OP_SW: begin
                dec.alu_op = ALU_ADD;
                dec.imm    = sext16(imm16);
                dec.mem_wr = 1'b1;
            end
            OP_ANDI: begin
                dec.alu_op = ALU_AND;
                dec.imm    = {16'd0, imm16};
            end
            OP_ORI: begin
                dec.alu_op = ALU_OR;
                dec.imm    = {16'd0, imm16};
            end
            OP_LUI: begin
                dec.alu_op = ALU_LUI;
                dec.imm    = {imm16, 16'd0};
            end
            OP_BEQ: begin
                dec.alu_op = ALU_SUB;
                dec.imm    = {{14{imm16[15]}}, imm16, 2'b00};
                dec.branch = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.wr_en = !dec.illegal && op != OP_SW && op != OP_BEQ && dec.dst != 5'd0;
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS-32 decode stage with write-before-read bypass, load-use stall and ID/EX register
module id_stage
    import id_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic [4:0]  read_reg_1,
    output logic [4:0]  read_reg_2,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    input  logic        wb_en,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_op_a,
    output logic [31:0] out_op_b,
    output logic [31:0] out_imm,
    output logic [4:0]  out_dst,
    output logic        out_wr_en,
    output logic [3:0]  out_alu_op,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic        out_branch,
    output logic        out_illegal
);

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rt;
    dec_t        dec;
    logic        stall;
    logic        xfer;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    dec_t        dec_q, dec_d;

    id_decoder u_dec (
        .instr  (in_instr),
        .rs     (rs),
        .rt     (rt),
        .use_rt (use_rt),
        .dec    (dec)
    );

    assign read_reg_1 = rs;
    assign read_reg_2 = rt;

    always_comb begin
        // a held load whose result feeds the incoming instruction must drain first
        stall    = valid_q && dec_q.mem_rd && dec_q.dst != 5'd0 && in_valid &&
                   (rs == dec_q.dst || (use_rt && rt == dec_q.dst));
        in_ready = !stall && !flush && (!valid_q || out_ready);
        xfer     = in_valid && in_ready;
        valid_d  = xfer || (valid_q && !out_ready && !flush);
        pc_d     = xfer ? in_pc : pc_q;
        dec_d    = xfer ? dec : dec_q;
        op_a_d   = !xfer ? op_a_q :
                   rs == 5'd0 ? 32'd0 :
                   (wb_en && wb_reg == rs) ? wb_data : read_data_1;
        op_b_d   = !xfer ? op_b_q :
                   rt == 5'd0 ? 32'd0 :
                   (wb_en && wb_reg == rt) ? wb_data : read_data_2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            dec_q   <= dec_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_op_a    = op_a_q;
    assign out_op_b    = op_b_q;
    assign out_imm     = dec_q.imm;
    assign out_dst     = dec_q.dst;
    assign out_wr_en   = dec_q.wr_en;
    assign out_alu_op  = dec_q.alu_op;
    assign out_mem_rd  = dec_q.mem_rd;
    assign out_mem_wr  = dec_q.mem_wr;
    assign out_branch  = dec_q.branch;
    assign out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus a randomized scoreboard run for id_stage
module tb_id_stage;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready;
    logic [4:0]  read_reg_1, read_reg_2;
    logic [31:0] read_data_1, read_data_2;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [31:0] out_pc, out_op_a, out_op_b, out_imm;
    logic [4:0]  out_dst;
    logic        out_wr_en;
    logic [3:0]  out_alu_op;
    logic        out_mem_rd, out_mem_wr, out_branch, out_illegal;
    logic [31:0] rf [32];
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [3:0]  alu;
        logic        wr_en;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        illegal;
    } rec_t;

    id_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm), .out_dst(out_dst),
        .out_wr_en(out_wr_en), .out_alu_op(out_alu_op), .out_mem_rd(out_mem_rd),
        .out_mem_wr(out_mem_wr), .out_branch(out_branch), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // register file environment, written only through the writeback port
    assign read_data_1 = rf[read_reg_1];
    assign read_data_2 = rf[read_reg_2];
    always @(posedge clk) if (wb_en) rf[wb_reg] <= wb_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
        in_valid = v;
        in_instr = i;
        in_pc    = p;
    endtask

    // expected ID/EX contents from the instruction-set rules
    function automatic rec_t model(input logic [31:0] i, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        rec_t r;
        logic [5:0] op;
        logic [5:0] fn;
        int simm;
        op   = i[31:26];
        fn   = i[5:0];
        simm = int'($signed(i[15:0]));
        r      = '0;
        r.pc   = pc;
        r.op_a = a;
        r.op_b = b;
        if (op == 6'h00) begin
            r.dst     = i[15:11];
            r.illegal = !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00});
            r.alu     = fn == 6'h20 ? ALU_ADD : fn == 6'h22 ? ALU_SUB : fn == 6'h24 ? ALU_AND :
                        fn == 6'h25 ? ALU_OR : fn == 6'h2A ? ALU_SLT : ALU_SLL;
            r.imm     = fn == 6'h00 ? 32'(i[10:6]) : 32'd0;
        end else begin
            r.dst     = i[20:16];
            r.illegal = !(op inside {6'h08, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0F, 6'h04});
            r.alu     = op == 6'h0C ? ALU_AND : op == 6'h0D ? ALU_OR : op == 6'h0F ? ALU_LUI :
                        op == 6'h04 ? ALU_SUB : ALU_ADD;
            r.imm     = op inside {6'h0C, 6'h0D} ? 32'(i[15:0]) :
                        op == 6'h0F ? 32'(i[15:0]) * 32'd65536 :
                        op == 6'h04 ? 32'(simm * 4) : 32'(simm);
            r.mem_rd  = op == 6'h23;
            r.mem_wr  = op == 6'h2B;
            r.branch  = op == 6'h04;
        end
        r.wr_en = !r.illegal && !r.mem_wr && !r.branch && r.dst != 5'd0;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        sh  = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 15))
            0:  return {6'h00, rs, rt, rd, sh, 6'h20};
            1:  return {6'h00, rs, rt, rd, sh, 6'h22};
            2:  return {6'h00, rs, rt, rd, sh, 6'h24};
            3:  return {6'h00, rs, rt, rd, sh, 6'h25};
            4:  return {6'h00, rs, rt, rd, sh, 6'h2A};
            5:  return {6'h00, rs, rt, rd, sh, 6'h00};
            6:  return {6'h00, rs, rt, rd, sh, 6'h21};
            7:  return {6'h08, rs, rt, imm};
            8:  return {6'h23, rs, rt, imm};
            9:  return {6'h23, rs, rt, imm};
            10: return {6'h2B, rs, rt, imm};
            11: return {6'h0C, rs, rt, imm};
            12: return {6'h0D, rs, rt, imm};
            13: return {6'h0F, rs, rt, imm};
            14: return {6'h04, rs, rt, imm};
            default: return {6'h3F, rs, rt, imm};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 32; k++) begin
            wb_en   = 1'b1;
            wb_reg  = 5'(k);
            wb_data = $urandom | 32'h1;
            tick();
        end
        wb_en = 1'b0;
        drive(1'b1, 32'h00A32020, 32'h1234);
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_op_a, out_op_b, out_imm} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h %h %h %h %h, expected all zero", out_valid, out_pc, out_op_a, out_op_b, out_imm);
        end
        n_checks++;
        if ({out_dst, out_wr_en, out_alu_op, out_mem_rd, out_mem_wr, out_branch, out_illegal} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h, expected 0", {out_dst, out_wr_en, out_alu_op, out_mem_rd, out_mem_wr, out_branch, out_illegal});
        end
        n_checks++;
        if ({in_ready, read_reg_1, read_reg_2} !== {1'b1, 5'd5, 5'd3}) begin
            n_fail++;
            $display("FAIL reset_comb: got ready=%b rr1=%0d rr2=%0d, expected 1 5 3", in_ready, read_reg_1, read_reg_2);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_dst} !== {1'b1, 32'h1234, 5'd4}) begin
            n_fail++;
            $display("FAIL reset_first_xfer: got v=%b pc=%h dst=%0d, expected 1 1234 4", out_valid, out_pc, out_dst);
        end
        drive(1'b0, '0, '0);
        tick();
    endtask

    task automatic test_addi();
        drive(1'b1, 32'h20010005, 32'h100);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL addi_ready: got %b, expected 1", in_ready);
        end
        tick();
        drive(1'b0, '0, '0);
        n_checks++;
        if ({out_valid, out_dst, out_imm, out_op_a, out_alu_op, out_wr_en, out_pc} !==
            {1'b1, 5'd1, 32'd5, 32'd0, ALU_ADD, 1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL addi_fields: got v=%b dst=%0d imm=%h a=%h alu=%0d wr=%b pc=%h", out_valid, out_dst, out_imm, out_op_a, out_alu_op, out_wr_en, out_pc);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_drain: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_reg = 5'd2; wb_data = 32'd0;
        tick();
        wb_data = 32'hD5;
        drive(1'b1, 32'h00421820, 32'h140);
        tick();
        wb_en = 1'b0;
        drive(1'b0, '0, '0);
        n_checks++;
        if ({out_valid, out_op_a, out_op_b, out_dst, out_alu_op, out_wr_en} !==
            {1'b1, 32'hD5, 32'hD5, 5'd3, ALU_ADD, 1'b1}) begin
            n_fail++;
            $display("FAIL bypass: got v=%b a=%h b=%h dst=%0d alu=%0d wr=%b, expected 1 d5 d5 3 0 1", out_valid, out_op_a, out_op_b, out_dst, out_alu_op, out_wr_en);
        end
        tick();
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h8C040000, 32'h200);
        tick();
        n_checks++;
        if ({out_valid, out_mem_rd, out_dst, out_wr_en, out_imm} !== {1'b1, 1'b1, 5'd4, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL lw_fields: got v=%b rd=%b dst=%0d wr=%b imm=%h", out_valid, out_mem_rd, out_dst, out_wr_en, out_imm);
        end
        drive(1'b1, 32'h00812820, 32'h204);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_stall: got in_ready=%b, expected 0", in_ready);
        end
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL load_use_bubble: got v=%b ready=%b, expected 0 1", out_valid, in_ready);
        end
        tick();
        drive(1'b0, '0, '0);
        n_checks++;
        if ({out_valid, out_pc, out_op_a, out_op_b, out_dst} !== {1'b1, 32'h204, rf[4], rf[1], 5'd5}) begin
            n_fail++;
            $display("FAIL load_use_add: got v=%b pc=%h a=%h b=%h dst=%0d, expected 1 204 %h %h 5", out_valid, out_pc, out_op_a, out_op_b, out_dst, rf[4], rf[1]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'h34069234, 32'h300);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 32'h00224022, 32'h304);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({in_ready, out_valid, out_pc, out_imm, out_dst, out_alu_op, out_op_a} !==
                {1'b0, 1'b1, 32'h300, 32'h00009234, 5'd6, ALU_OR, 32'd0}) begin
                n_fail++;
                $display("FAIL hold_%0d: got rdy=%b v=%b pc=%h imm=%h dst=%0d alu=%0d a=%h", c, in_ready, out_valid, out_pc, out_imm, out_dst, out_alu_op, out_op_a);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release_ready: got %b, expected 1", in_ready);
        end
        tick();
        drive(1'b0, '0, '0);
        n_checks++;
        if ({out_valid, out_pc, out_dst, out_alu_op, out_op_a, out_op_b} !==
            {1'b1, 32'h304, 5'd8, ALU_SUB, rf[1], rf[2]}) begin
            n_fail++;
            $display("FAIL hold_release_sub: got v=%b pc=%h dst=%0d alu=%0d a=%h b=%h", out_valid, out_pc, out_dst, out_alu_op, out_op_a, out_op_b);
        end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h20090001, 32'h400);
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: got out_valid=%b, expected 1", out_valid);
        end
        drive(1'b1, 32'h200A0002, 32'h404);
        flush = 1'b1;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got %b, expected 0", in_ready);
        end
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_kill: got out_valid=%b, expected 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h20090001, 32'h500);
        tick();
        drive(1'b1, 32'hFC000000, 32'h504);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_pc, out_dst, out_wr_en} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b pc=%h dst=%0d wr=%b, expected 0", out_valid, out_pc, out_dst, out_wr_en);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got out_valid=%b, expected 0", out_valid);
        end
        rst = 1'b0;
        tick();
        drive(1'b0, '0, '0);
        n_checks++;
        if ({out_valid, out_illegal, out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_pc} !==
            {1'b1, 1'b1, 4'b0000, 32'h504}) begin
            n_fail++;
            $display("FAIL reset_illegal: got v=%b ill=%b wr=%b rd=%b wr=%b br=%b pc=%h", out_valid, out_illegal, out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_pc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr [10] = '{32'h3C0BABCD, 32'h1022FFFC, 32'hAC230008, 32'h00026140, 32'h302D8001,
                                    32'h2020FFFF, 32'h0022702A, 32'h0022703F, 32'h00221825, 32'h8C25FFF8};
        logic [31:0] imm [10]   = '{32'hABCD0000, 32'hFFFFFFF0, 32'h8, 32'h5, 32'h8001,
                                    32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'hFFFFFFF8};
        logic [4:0]  dst [10]   = '{5'd11, 5'd2, 5'd3, 5'd12, 5'd13, 5'd0, 5'd14, 5'd14, 5'd3, 5'd5};
        logic [3:0]  alu [10]   = '{ALU_LUI, ALU_SUB, ALU_ADD, ALU_SLL, ALU_AND,
                                    ALU_ADD, ALU_SLT, ALU_PASS, ALU_OR, ALU_ADD};
        // wr_en, mem_rd, mem_wr, branch, illegal
        logic [4:0]  flg [10]   = '{5'b10000, 5'b00010, 5'b00100, 5'b10000, 5'b10000,
                                    5'b00000, 5'b10000, 5'b00001, 5'b10000, 5'b11000};
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, instr[n], 32'h600 + 32'(n * 4));
            tick();
            n_checks++;
            if ({out_valid, out_pc, out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_illegal} !==
                {1'b1, 32'h600 + 32'(n * 4), flg[n]}) begin
                n_fail++;
                $display("FAIL b2b_flags_%0d: got v=%b pc=%h flags=%b, expected flags %b", n, out_valid, out_pc, {out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_illegal}, flg[n]);
            end
            if (!flg[n][0]) begin
                n_checks++;
                if ({out_imm, out_dst, out_alu_op} !== {imm[n], dst[n], alu[n]}) begin
                    n_fail++;
                    $display("FAIL b2b_fields_%0d: got imm=%h dst=%0d alu=%0d, expected %h %0d %0d", n, out_imm, out_dst, out_alu_op, imm[n], dst[n], alu[n]);
                end
            end
        end
        drive(1'b0, '0, '0);
        tick();
        tick();
    endtask

    task automatic test_random();
        rec_t        q[$];
        rec_t        nr;
        logic        exp_stall, exp_ready, accept, pop, use_rt;
        logic [4:0]  rs, rt;
        logic [31:0] a, b;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL random_start: got out_valid=%b, expected 0", out_valid);
        end
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC);
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
            wb_en     = 1'($urandom);
            wb_reg    = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            @(negedge clk);
            rs        = in_instr[25:21];
            rt        = in_instr[20:16];
            use_rt    = in_instr[31:26] inside {6'h00, 6'h2B, 6'h04};
            exp_stall = q.size() != 0 && q[0].mem_rd && q[0].dst != 5'd0 && in_valid &&
                        (rs == q[0].dst || (use_rt && rt == q[0].dst));
            exp_ready = !exp_stall && !flush && (q.size() == 0 || out_ready);
            n_checks++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rnd_ready cycle %0d: got %b, expected %b", c, in_ready, exp_ready);
            end
            n_checks++;
            if ({read_reg_1, read_reg_2} !== {rs, rt}) begin
                n_fail++;
                $display("FAIL rnd_raddr cycle %0d: got %0d %0d, expected %0d %0d", c, read_reg_1, read_reg_2, rs, rt);
            end
            accept = in_valid && exp_ready;
            pop    = q.size() != 0 && out_ready;
            a  = rs == 5'd0 ? 32'd0 : (wb_en && wb_reg == rs) ? wb_data : rf[rs];
            b  = rt == 5'd0 ? 32'd0 : (wb_en && wb_reg == rt) ? wb_data : rf[rt];
            nr = model(in_instr, in_pc, a, b);
            tick();
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (accept) q.push_back(nr);
            end
            n_checks++;
            if (out_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_valid cycle %0d: got %b, expected %b", c, out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_checks++;
                if ({out_pc, out_op_a, out_op_b, out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_illegal} !==
                    {q[0].pc, q[0].op_a, q[0].op_b, q[0].wr_en, q[0].mem_rd, q[0].mem_wr, q[0].branch, q[0].illegal}) begin
                    n_fail++;
                    $display("FAIL rnd_data cycle %0d: got pc=%h a=%h b=%h fl=%b, expected pc=%h a=%h b=%h fl=%b", c,
                             out_pc, out_op_a, out_op_b, {out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_illegal},
                             q[0].pc, q[0].op_a, q[0].op_b, {q[0].wr_en, q[0].mem_rd, q[0].mem_wr, q[0].branch, q[0].illegal});
                end
                if (!q[0].illegal) begin
                    n_checks++;
                    if ({out_imm, out_dst, out_alu_op} !== {q[0].imm, q[0].dst, q[0].alu}) begin
                        n_fail++;
                        $display("FAIL rnd_decode cycle %0d: got imm=%h dst=%0d alu=%0d, expected %h %0d %0d", c,
                                 out_imm, out_dst, out_alu_op, q[0].imm, q[0].dst, q[0].alu);
                    end
                end
            end
        end
        drive(1'b0, '0, '0);
        flush = 1'b0;
        wb_en = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #2;
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid  input  1  fetch presents an instruction.
REQ-004 in_instr  input  32  MIPS-32 instruction word.
REQ-005 in_pc  input  32  PC of in_instr.
REQ-006 in_ready  output  1  stage accepts in_instr this cycle.
REQ-007 read_reg_1, read_reg_2  output  5 each  register-file read addresses: rs = in_instr[25:21], rt = in_instr[20:16]; combinational.
REQ-008 read_data_1, read_data_2  input  32 each  register-file combinational read data.
REQ-009 wb_en, wb_reg, wb_data  input  1/5/32  writeback write port, same signals that drive the register-file write port.
REQ-010 flush  input  1  branch redirect; kill held and incoming instruction.
REQ-011 out_ready  input  1  execute stage accepts the output register.
REQ-012 out_valid, out_pc[31:0], out_op_a[31:0], out_op_b[31:0], out_imm[31:0], out_dst[4:0], out_wr_en, out_alu_op[3:0], out_mem_rd, out_mem_wr, out_branch, out_illegal  output  ID/EX pipeline register contents.

Function
REQ-013 Transfer occurs when in_valid && in_ready; decoded fields are captured into the output register at that posedge; latency exactly 1 cycle.
REQ-014 in_ready = !stall && !flush && (!out_valid || out_ready).
REQ-015 Output register holds all fields stable while out_valid && !out_ready.
REQ-016 When out_ready && out_valid and no transfer occurs, out_valid clears at next posedge.
REQ-017 Operand select: source reg 0 -> 0; else wb_en && wb_reg == source -> wb_data (write-before-read bypass); else read_data_n.
REQ-018 Decode: R-type (op 0x00) funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, SLL 0x00: dst = rd, op_b = rt value; SLL uses shamt in out_imm[4:0].
REQ-019 I-type ADDI 0x08 and LW 0x23, SW 0x2B: out_imm sign-extended imm16; ANDI 0x0C, ORI 0x0D: zero-extended; LUI 0x0F: imm16 << 16; BEQ 0x04: sign-extended imm16 << 2, out_branch=1; I-type dst = rt.
REQ-020 out_wr_en = 0 for SW, BEQ, illegal, or dst == 0; out_mem_rd = LW, out_mem_wr = SW.
REQ-021 Unknown opcode/funct: out_illegal=1, out_wr_en=out_mem_rd=out_mem_wr=out_branch=0, still passed through with out_valid=1.
REQ-022 Load-use stall: stall=1 when out_valid && out_mem_rd && out_dst != 0 && in_valid && out_dst matches a source actually used by in_instr (rt unused by I-type except SW/BEQ).
REQ-023 During stall with out_ready=1, a bubble (out_valid=0) is inserted; stall resolves the next cycle; exactly one bubble per load-use pair.
REQ-024 flush: out_valid=0 at next posedge regardless of out_ready; in_ready=0 that cycle; flush overrides stall and transfer.

Reset
REQ-025 While rst is high, out_valid and every output-register field are 0, asynchronously; combinational outputs follow REQ-007/REQ-014.
REQ-026 Reset asserted mid-transfer discards the held instruction; first transfer is possible on the first posedge after rst deasserts.

Structure
REQ-027 Shared package id_pkg holds opcode and funct constants, the 4-bit alu_op encoding (ADD, SUB, AND, OR, SLT, SLL, LUI, PASS) and the decoded-instruction struct.
REQ-028 Combinational decode is one sub-module, id_decoder; id_stage holds the handshake, bypass, stall and output register.

Verification
REQ-029 addi $1,$0,5 (0x20010005), out_ready=1 -> next cycle out_valid=1, out_dst=1, out_imm=5, out_op_a=0, out_alu_op=ADD, out_wr_en=1.
REQ-030 add $3,$2,$2 (0x00421820) with read_data=0, wb_en=1, wb_reg=2, wb_data=0xD5 -> out_op_a=out_op_b=0xD5, out_dst=3.
REQ-031 lw $4,0($0) (0x8C040000) then add $5,$4,$1 (0x00812820) back-to-back -> in_ready=0 one cycle, one bubble, add emerges 2 cycles after lw.
REQ-032 out_ready=0 for 3 cycles with valid output -> all out_* stable, in_ready=0; release -> next instruction captured.
REQ-033 flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, incoming instruction dropped.
REQ-034 rst pulsed mid-stream; opcode 0x3F -> out_valid=0 during reset; after reset out_illegal=1, out_wr_en=0.
